uart_tx_io: RTL and testbench
=============================

UART_TX_IO -- requirements
Module: uart_tx_io

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, transmit FIFO entries; power of two, 2..64.
REQ-003 clk_i  input  1  single system clock; all state updates on rising edge.
REQ-004 rstn_i  input  1  reset, asynchronous assert, active-low.
REQ-005 wr_en_i  input  1  one-cycle store strobe from the core's I/O address decode (store to 0x4000).
REQ-006 wr_data_i  input  32  store data from core rs2; only bits [7:0] are used.
REQ-007 ovf_clr_i  input  1  clears the sticky overflow flag.
REQ-008 tx_o  output  1  UART serial line, 8N1, LSB first, idle high; driven from a flop.
REQ-009 busy_o  output  1  high while FIFO is non-empty or a frame is in progress.
REQ-010 full_o  output  1  FIFO holds FIFO_DEPTH entries.
REQ-011 count_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 ovf_o  output  1  sticky: a write was dropped because the FIFO was full.

Function
REQ-013 A push SHALL occur on a rising edge where wr_en_i=1 and (full_o=0 or a pop occurs on the same edge); data pushed = wr_data_i[7:0].
REQ-014 wr_en_i=1 while full_o=1 with no same-edge pop SHALL drop the byte, leave the FIFO unchanged, and set ovf_o=1 on that edge.
REQ-015 ovf_o SHALL clear on an edge with ovf_clr_i=1; a same-edge drop SHALL take priority (ovf_o stays 1).
REQ-016 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; count_o SHALL change by +1, -1 or 0 (simultaneous push and pop) per edge.
REQ-017 FSM states: IDLE, START, DATA, STOP.
REQ-018 IDLE: tx_o=1; if count_o>0, pop the head byte into the shift register and go to START on the same edge.
REQ-019 START: tx_o=0 for CLKS_PER_BIT cycles, then DATA.
REQ-020 DATA: drive shift register bit 0, shift right every CLKS_PER_BIT cycles; after 8 bits go to STOP.
REQ-021 STOP: tx_o=1 for CLKS_PER_BIT cycles; at its end, if count_o>0 pop and enter START directly (no idle gap), else IDLE.
REQ-022 A baud counter SHALL count 0..CLKS_PER_BIT-1, reloading to 0 on every state/bit transition; each bit period is exactly CLKS_PER_BIT cycles, frame exactly 10*CLKS_PER_BIT.
REQ-023 Latency: for a push into an empty FIFO with FSM in IDLE at edge N, the pop SHALL occur at edge N+1 and tx_o SHALL be 0 from edge N+2.
REQ-024 A bit counter (0..7) SHALL track DATA bits; it resets on entry to DATA.
REQ-025 busy_o = (state != IDLE) or (count_o != 0), combinational from registered state.
REQ-026 Pushes during a frame SHALL NOT disturb the byte being shifted.

Reset
REQ-027 On rstn_i=0, asynchronously: state=IDLE, tx_o=1, FIFO pointers and count_o=0, full_o=0, ovf_o=0, busy_o=0, baud and bit counters=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame, discard all queued bytes, and force tx_o=1 without waiting for a clock edge.
REQ-029 After reset release the first wr_en_i SHALL be accepted on the first rising edge.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Single write 0x00000041 at edge N -> tx_o low from N+2; line sequence 0,1,0,0,0,0,0,1,0,1 each held 4 cycles; busy_o falls at N+42.
REQ-031 Five writes 0x11..0x15 on consecutive edges from IDLE -> first popped at next edge, remaining four fill FIFO, no drop, ovf_o=0; five frames back-to-back with no idle cycle between stop and next start.
REQ-032 Six back-to-back writes while a frame is active and FIFO full after four -> two dropped, ovf_o=1, count_o=4; ovf_clr_i pulse -> ovf_o=0 next edge.
REQ-033 Write while full_o=1 on the same edge as STOP-end pop -> write accepted, count_o unchanged, ovf_o stays 0.
REQ-034 Assert rstn_i=0 mid DATA of a frame with two bytes queued -> tx_o=1 immediately, count_o=0, busy_o=0; no further frames after release until a new write.

Source files
------------

// File: rtl/uart_tx_io_if.sv
// rtl/uart_tx_io_if.sv - Core-side store/status bundle for the UART transmitter
//
// Purpose: groups the store strobe, store data, overflow clear and the UART
// line/status outputs so the core and the transmitter connect through one port.
// Signals:
//   wr_en_i    core -> uart  one-cycle store strobe from the I/O address decode
//   wr_data_i  core -> uart  store data (bits [7:0] carry the byte)
//   ovf_clr_i  core -> uart  clears the sticky overflow flag
//   tx_o       uart -> pad   serial line, 8N1, LSB first, idle high
//   busy_o     uart -> core  FIFO non-empty or frame in progress
//   full_o     uart -> core  FIFO holds FIFO_DEPTH entries
//   count_o    uart -> core  FIFO occupancy
//   ovf_o      uart -> core  sticky "a write was dropped" flag
interface uart_tx_io_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en_i;
  logic [31:0]   wr_data_i;
  logic          ovf_clr_i;
  logic          tx_o;
  logic          busy_o;
  logic          full_o;
  logic [CW-1:0] count_o;
  logic          ovf_o;

  modport master (
    output wr_en_i, wr_data_i, ovf_clr_i,
    input  tx_o, busy_o, full_o, count_o, ovf_o
  );

  modport slave (
    input  wr_en_i, wr_data_i, ovf_clr_i,
    output tx_o, busy_o, full_o, count_o, ovf_o
  );
endinterface

// File: rtl/uart_tx_io.sv
// rtl/uart_tx_io.sv - Memory-mapped UART transmitter with transmit FIFO
//
// Purpose: accepts bytes from core stores into a FIFO and serialises them as
// 8N1 frames, LSB first, CLKS_PER_BIT clocks per bit, with back-to-back frames
// when the FIFO has more data at the end of a stop bit.
// Ports:
//   clk_i   system clock, rising edge
//   rstn_i  asynchronous active-low reset
//   bus     uart_tx_io_if.slave (store strobe/data, overflow clear, line and status)
module uart_tx_io #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  uart_tx_io_if.slave bus
);
  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              CW        = AW + 1;
  localparam logic [15:0]     BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [15:0]   baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          lead_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rptr_q;
  logic [AW-1:0] wptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovf_q;
  logic          ovf_d;

  logic          baud_end;
  logic          fifo_nempty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          unused_hi;

  assign unused_hi   = ^bus.wr_data_i[31:8];

  assign baud_end    = (baud_q == BAUD_LAST);
  assign fifo_nempty = (count_q != '0);
  assign full        = (count_q == DEPTH_C);

  // The FSM takes the head byte either from idle or at the last cycle of a
  // stop bit; a same-edge pop frees a slot, so a write to a full FIFO is
  // still accepted on that edge.
  assign pop  = fifo_nempty && ((state_q == IDLE) || ((state_q == STOP) && baud_end));
  assign push = bus.wr_en_i && (!full || pop);
  assign drop = bus.wr_en_i && full && !pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // A drop on the same edge as a clear wins, so no overflow event is lost.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= bus.wr_data_i[7:0];
  end

  // tx_q always carries the line value of the bit currently being timed.
  // Leaving IDLE, the line stays high for one extra cycle (lead_q) while the
  // popped byte settles; the start bit then gets its full CLKS_PER_BIT on the
  // line. Entering START from STOP drives low on the same edge so consecutive
  // frames have no gap.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      lead_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          bit_q  <= '0;
          if (pop) begin
            shift_q <= mem_q[rptr_q];
            lead_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (lead_q) begin
            lead_q <= 1'b0;
            tx_q   <= 1'b0;
          end else if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rptr_q];
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx_o    = tx_q;
  assign bus.busy_o  = (state_q != IDLE) || fifo_nempty;
  assign bus.full_o  = full;
  assign bus.count_o = count_q;
  assign bus.ovf_o   = ovf_q;
endmodule

// File: tb/tb_uart_tx_io.sv
// tb/tb_uart_tx_io.sv - Directed self-checking bench for uart_tx_io (4 clocks/bit, 4-entry FIFO)
module tb_uart_tx_io;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  uart_tx_io_if #(.FIFO_DEPTH(4)) bus ();

  uart_tx_io #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a start bit, then samples each bit mid-period.
  task automatic rx_frame(output logic [7:0] b, output bit ok);
    int n;
    ok = 1'b1;
    b  = '0;
    n  = 0;
    while (bus.tx_o !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    if (bus.tx_o !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (2) tick();
    for (int i = 0; i < 8; i++) begin
      repeat (4) tick();
      b[i] = bus.tx_o;
    end
    repeat (4) tick();
    if (bus.tx_o !== 1'b1) ok = 1'b0;
  endtask

  function automatic logic b2b_line(input int k);
    logic [7:0] byt;
    int f;
    int b;
    f   = k / 40;
    b   = (k % 40) / 4;
    byt = 8'h11 + 8'(f);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return byt[b-1];
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    bus.wr_en_i = 1'b0;
    bus.wr_data_i = '0;
    bus.ovf_clr_i = 1'b0;
    repeat (3) tick();
    checks++; if (bus.tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", bus.tx_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.full_o !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full_o); end
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count_o); end
    checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf_o); end
    rstn = 1'b1;
  endtask

  // Runs straight after reset release: the write lands on the first edge.
  task automatic test_single();
    logic [9:0] seq;
    seq = 10'b1010000010;
    bus.wr_en_i = 1'b1;
    bus.wr_data_i = 32'h0000_0041;
    tick();
    bus.wr_en_i = 1'b0;
    checks++; if (bus.count_o !== 3'd1) begin errors++; $display("FAIL single_push_count got=%0d exp=1", bus.count_o); end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", bus.busy_o); end
    checks++; if (bus.tx_o !== 1'b1) begin errors++; $display("FAIL single_tx_n got=%b exp=1", bus.tx_o); end
    tick();
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL single_pop_count got=%0d exp=0", bus.count_o); end
    checks++; if (bus.tx_o !== 1'b1) begin errors++; $display("FAIL single_tx_n1 got=%b exp=1", bus.tx_o); end
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        checks++;
        if (bus.tx_o !== seq[b]) begin
          errors++;
          $display("FAIL single_line bit=%0d cyc=%0d got=%b exp=%b", b, c, bus.tx_o, seq[b]);
        end
      end
    end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL single_busy_n41 got=%b exp=1", bus.busy_o); end
    tick();
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_n42 got=%b exp=0", bus.busy_o); end
    checks++; if (bus.tx_o !== 1'b1) begin errors++; $display("FAIL single_idle_tx got=%b exp=1", bus.tx_o); end
  endtask

  task automatic test_back_to_back();
    logic e;
    for (int t = 0; t < 202; t++) begin
      if (t < 5) begin
        bus.wr_en_i = 1'b1;
        bus.wr_data_i = 32'h11 + t;
      end else begin
        bus.wr_en_i = 1'b0;
      end
      tick();
      if (t == 4) begin
        checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", bus.count_o); end
        checks++; if (bus.full_o !== 1'b1) begin errors++; $display("FAIL b2b_full got=%b exp=1", bus.full_o); end
        checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL b2b_ovf got=%b exp=0", bus.ovf_o); end
      end
      if (t >= 2) begin
        e = b2b_line(t - 2);
        checks++;
        if (bus.tx_o !== e) begin
          errors++;
          $display("FAIL b2b_line k=%0d got=%b exp=%b", t - 2, bus.tx_o, e);
        end
      end
    end
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL b2b_busy_end got=%b exp=1", bus.busy_o); end
    tick();
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL b2b_busy_idle got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_overflow();
    logic [7:0] got;
    bit ok;
    bit seen;
    int n;
    bus.wr_en_i = 1'b1;
    bus.wr_data_i = 32'hFF;
    tick();
    bus.wr_en_i = 1'b0;
    tick();
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL ovf_popped got=%0d exp=0", bus.count_o); end
    for (int i = 0; i < 6; i++) begin
      bus.wr_en_i = 1'b1;
      bus.wr_data_i = 32'h21 + i;
      tick();
      if (i == 3) begin
        checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL ovf_fill_count got=%0d exp=4", bus.count_o); end
        checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_fill_flag got=%b exp=0", bus.ovf_o); end
      end
    end
    checks++; if (bus.ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", bus.ovf_o); end
    checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", bus.count_o); end
    bus.wr_data_i = 32'h99;
    bus.ovf_clr_i = 1'b1;
    tick();
    checks++; if (bus.ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_drop_beats_clr got=%b exp=1", bus.ovf_o); end
    bus.wr_en_i = 1'b0;
    tick();
    bus.ovf_clr_i = 1'b0;
    checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", bus.ovf_o); end
    for (int i = 0; i < 4; i++) begin
      rx_frame(got, ok);
      checks++;
      if (!ok || got !== 8'(8'h21 + i)) begin
        errors++;
        $display("FAIL ovf_frame idx=%0d got=%02h ok=%0d exp=%02h", i, got, ok, 8'h21 + i);
      end
    end
    n = 0;
    while (bus.busy_o !== 1'b0 && n < 50) begin tick(); n++; end
    checks++; if (bus.busy_o !== 1'b0 || bus.count_o !== 3'd0) begin errors++; $display("FAIL ovf_drain busy=%b count=%0d exp busy=0 count=0", bus.busy_o, bus.count_o); end
    seen = 1'b0;
    repeat (60) begin tick(); if (bus.tx_o !== 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ovf_no_dropped_frame got_low=%b exp=0", seen); end
  endtask

  task automatic test_full_pop_same_edge();
    logic [7:0] got;
    logic [7:0] exp_b;
    bit ok;
    int n;
    for (int i = 0; i < 5; i++) begin
      bus.wr_en_i = 1'b1;
      bus.wr_data_i = (i == 0) ? 32'hFF : 32'h30 + i;
      tick();
    end
    bus.wr_en_i = 1'b0;
    repeat (37) tick();
    checks++; if (bus.full_o !== 1'b1 || bus.count_o !== 3'd4) begin errors++; $display("FAIL fps_pre full=%b count=%0d exp full=1 count=4", bus.full_o, bus.count_o); end
    bus.wr_en_i = 1'b1;
    bus.wr_data_i = 32'h5A;
    tick();
    bus.wr_en_i = 1'b0;
    checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL fps_count got=%0d exp=4", bus.count_o); end
    checks++; if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL fps_ovf got=%b exp=0", bus.ovf_o); end
    checks++; if (bus.tx_o !== 1'b0) begin errors++; $display("FAIL fps_no_gap got=%b exp=0", bus.tx_o); end
    for (int i = 0; i < 5; i++) begin
      exp_b = (i == 4) ? 8'h5A : 8'(8'h31 + i);
      rx_frame(got, ok);
      checks++;
      if (!ok || got !== exp_b) begin
        errors++;
        $display("FAIL fps_frame idx=%0d got=%02h ok=%0d exp=%02h", i, got, ok, exp_b);
      end
    end
    n = 0;
    while (bus.busy_o !== 1'b0 && n < 50) begin tick(); n++; end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL fps_idle got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got;
    bit ok;
    bit seen;
    bus.wr_en_i = 1'b1;
    bus.wr_data_i = 32'h00;
    tick();
    bus.wr_data_i = 32'h77;
    tick();
    bus.wr_data_i = 32'h78;
    tick();
    bus.wr_en_i = 1'b0;
    repeat (10) tick();
    checks++; if (bus.tx_o !== 1'b0 || bus.count_o !== 3'd2) begin errors++; $display("FAIL rmf_pre tx=%b count=%0d exp tx=0 count=2", bus.tx_o, bus.count_o); end
    rstn = 1'b0;
    #1;
    checks++; if (bus.tx_o !== 1'b1) begin errors++; $display("FAIL rmf_tx got=%b exp=1", bus.tx_o); end
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL rmf_count got=%0d exp=0", bus.count_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rmf_busy got=%b exp=0", bus.busy_o); end
    repeat (3) tick();
    rstn = 1'b1;
    seen = 1'b0;
    repeat (60) begin tick(); if (bus.tx_o !== 1'b1 || bus.busy_o !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmf_quiet activity=%b exp=0", seen); end
    bus.wr_en_i = 1'b1;
    bus.wr_data_i = 32'h55;
    tick();
    bus.wr_en_i = 1'b0;
    rx_frame(got, ok);
    checks++; if (!ok || got !== 8'h55) begin errors++; $display("FAIL rmf_new_frame got=%02h ok=%0d exp=55", got, ok); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop_same_edge();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
